// File: rtl/rr_grant_scheduler_pkg.sv
// Shared definitions for the round-robin grant scheduler and its picker.
// State codes, requester count and small index helpers.
package rr_grant_scheduler_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Modulo-3 increment; an out-of-range index folds back to requester 0.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  function automatic logic [N_REQ-1:0] onehot3(input logic [1:0] idx);
    logic [N_REQ-1:0] vec;
    case (idx)
      2'd0:    vec = 3'b001;
      2'd1:    vec = 3'b010;
      2'd2:    vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage

// File: rtl/rr_grant_scheduler_pick3.sv
// Combinational 3-way round-robin picker: searches last+1, last+2, last
// and reports the first requester found.
module rr_pick3
  import rr_grant_scheduler_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] sel
);

  logic [3:0] req_ext_s;
  logic [1:0] cand0_s;
  logic [1:0] cand1_s;
  logic [1:0] cand2_s;

  assign req_ext_s = {1'b0, req};

  // Priority search in rotating order starting just after the last owner.
  always_comb begin
    cand0_s = wrap_inc(last);
    cand1_s = wrap_inc(cand0_s);
    cand2_s = wrap_inc(cand1_s);
    valid   = 1'b1;
    sel     = cand0_s;
    if (req_ext_s[cand0_s]) begin
      sel = cand0_s;
    end else if (req_ext_s[cand1_s]) begin
      sel = cand1_s;
    end else if (req_ext_s[cand2_s]) begin
      sel = cand2_s;
    end else begin
      valid = 1'b0;
      sel   = 2'd0;
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler for one shared resource among 3 requesters, with a
// bounded hold time and an enforced idle gap between owners. Outputs are registered.
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int GAP      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] done,
  output logic [2:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_e        state_q,   state_d;
  logic [HW-1:0] hold_q,    hold_d;
  logic [GW-1:0] gap_q,     gap_d;
  logic [1:0]    owner_q,   owner_d;
  logic [1:0]    last_q,    last_d;
  logic [2:0]    grant_q,   grant_d;
  logic          busy_q,    busy_d;
  logic          timeout_q, timeout_d;

  logic       pick_valid_s;
  logic [1:0] pick_sel_s;
  logic [3:0] req_ext_s;
  logic [3:0] done_ext_s;
  logic       rel_normal_s;
  logic       rel_expiry_s;

  rr_pick3 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid_s),
    .sel   (pick_sel_s)
  );

  assign req_ext_s    = {1'b0, req};
  assign done_ext_s   = {1'b0, done};
  assign rel_normal_s = done_ext_s[owner_q] | ~req_ext_s[owner_q];
  assign rel_expiry_s = (hold_q == HOLD_LAST);

  // Next-state, counter and output computation; outputs follow the next state.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d = ST_GRANT;
          owner_d = pick_sel_s;
          last_d  = pick_sel_s;
          hold_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (rel_normal_s || rel_expiry_s) begin
          // Expiry only counts as a timeout when nothing else ended the grant.
          timeout_d = rel_expiry_s & ~rel_normal_s;
          gap_d     = '0;
          if (GAP > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
        last_d  = 2'd2;
        hold_d  = '0;
        gap_d   = '0;
      end
    endcase

    if (state_d == ST_GRANT) begin
      grant_d = onehot3(owner_d);
    end else begin
      grant_d = 3'b000;
    end
    busy_d = (state_d == ST_GRANT) || (state_d == ST_GAP);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      gap_q     <= '0;
      owner_q   <= 2'd0;
      last_q    <= 2'd2;
      grant_q   <= 3'b000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench: hand-derived vector table, targeted corner sequences,
// and randomized traffic against a behavioural round-robin model.
module tb_rr_grant_scheduler;

  localparam int MAX_HOLD = 8;
  localparam int GAP      = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;
  logic [6:0] outs;

  int checks   = 0;
  int failures = 0;

  rr_grant_scheduler #(.MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  assign outs = {grant, owner, busy, timeout};

  typedef struct {
    logic [2:0] req;
    logic [2:0] done;
    logic [6:0] exp;   // {grant, owner, busy, timeout}
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  bit m_granting;
  int m_gap_left;
  int m_cyc;
  int m_own;
  int m_last;
  bit m_to;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got={g=%b o=%0d b=%b t=%b} exp={g=%b o=%0d b=%b t=%b}",
               name, got[6:4], got[3:2], got[1], got[0], exp[6:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] r, input logic [2:0] d, input logic [2:0] g,
                     input logic [1:0] o, input logic b, input logic t);
    vec_t v;
    v.req  = r;
    v.done = d;
    v.exp  = {g, o, b, t};
    vecs.push_back(v);
  endtask

  task automatic do_reset(input logic [2:0] r);
    req   = r;
    done  = 3'b000;
    reset = 1'b1;
    tick();
    check("reset_state", outs, 7'b000_00_0_0);
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_granting = 1'b0;
    m_gap_left = 0;
    m_cyc      = 0;
    m_own      = 0;
    m_last     = 2;
    m_to       = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic [2:0] d);
    m_to = 1'b0;
    if (m_granting) begin
      if (d[m_own] || !r[m_own] || m_cyc == MAX_HOLD) begin
        m_to       = (m_cyc == MAX_HOLD) && !d[m_own] && r[m_own];
        m_granting = 1'b0;
        m_gap_left = GAP;
      end else begin
        m_cyc++;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (r != 3'b000) begin
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (m_last + k) % 3;
        if (r[idx]) begin
          m_own      = idx;
          m_last     = idx;
          m_granting = 1'b1;
          m_cyc      = 1;
          break;
        end
      end
    end
  endtask

  function automatic logic [6:0] model_outs();
    logic [2:0] g;
    logic [2:0] one;
    one = 3'b001;
    g   = m_granting ? (one << m_own) : 3'b000;
    return {g, 2'(m_own), (m_granting || m_gap_left > 0), m_to};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit early_to;
    logic [2:0] one;
    one  = 3'b001;
    req  = 3'b000;
    done = 3'b000;

    // Rotation with done on every third grant cycle, then foreign/own done.
    add(3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0);
    add(3'b111, 3'b001, 3'b000, 2'd0, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    add(3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0);
    add(3'b111, 3'b010, 3'b000, 2'd1, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0);
    add(3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0);
    add(3'b111, 3'b100, 3'b000, 2'd2, 1'b1, 1'b0);
    add(3'b111, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0);
    add(3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0);
    add(3'b111, 3'b110, 3'b001, 2'd0, 1'b1, 1'b0);
    add(3'b111, 3'b001, 3'b000, 2'd0, 1'b1, 1'b0);
    add(3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);

    do_reset(3'b111);
    check("held_in_reset_release", outs, 7'b000_00_0_0);
    foreach (vecs[i]) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end
    done = 3'b000;

    // Sole requester runs to expiry.
    do_reset(3'b010);
    tick();
    n = 0;
    early_to = 1'b0;
    while (grant == 3'b010 && n < 20) begin
      n++;
      if (timeout) early_to = 1'b1;
      tick();
    end
    check_int("hold_length", n, MAX_HOLD);
    check_int("timeout_during_grant", int'(early_to), 0);
    check("expiry_gap", outs, 7'b000_01_1_1);
    tick();
    check("expiry_idle", outs, 7'b000_01_0_0);
    tick();
    check("regrant_after_expiry", outs, 7'b010_01_1_0);

    // Requester withdraws mid-grant.
    req = 3'b000;
    tick();
    check("req_drop_release", outs, 7'b000_01_1_0);
    req = 3'b010;
    tick();
    tick();
    check("regrant_after_drop", outs, 7'b010_01_1_0);
    repeat (MAX_HOLD - 1) tick();
    check("last_hold_cycle", outs, 7'b010_01_1_0);
    done = 3'b010;
    tick();
    check("done_at_expiry_no_timeout", outs, 7'b000_01_1_0);
    done = 3'b000;

    // Asynchronous reset in the middle of a grant.
    req = 3'b001;
    tick();
    tick();
    check("grant_before_async_reset", outs, 7'b001_00_1_0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clears", outs, 7'b000_00_0_0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 3'b110;
    tick();
    check("first_grant_after_reset", outs, 7'b010_01_1_0);

    // Randomized traffic against the model.
    do_reset(3'b000);
    model_reset();
    req = 3'b000;
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      done = ($urandom_range(0, 9) == 0) ? (one << $urandom_range(0, 2)) : 3'b000;
      model_step(req, done);
      tick();
      check($sformatf("rand%0d", c), outs, model_outs());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
